// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared constants and elaboration-time helpers for the pipelined
// binary-to-BCD converter.
//   pow10(p)               : 32-bit constant 10^p
//   bits_for(v)            : number of bits needed to represent v (min 1)
//   digits_needed(bin_w)   : decimal digits needed for any bin_w-bit value
//   arith_width(bin_w, d)  : compare/subtract width used by every stage
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int MAX_DIGITS = 6;

    function automatic logic [31:0] pow10(input int p);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < p; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    function automatic int bits_for(input logic [63:0] v);
        int b;
        b = 1;
        for (int i = 0; i < 64; i++) begin
            if (v >= (64'd1 << i)) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

    function automatic int digits_needed(input int bin_w);
        logic [63:0] max_v;
        logic [63:0] lim;
        int          d;
        max_v = (64'd1 << bin_w) - 64'd1;
        lim   = 64'd10;
        d     = 1;
        for (int i = 0; i < MAX_DIGITS + 2; i++) begin
            if (lim <= max_v) begin
                lim = lim * 64'd10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

    // Wide enough for both the input word and the largest threshold 9*10^(d-1).
    function automatic int arith_width(input int bin_w, input int digits);
        int w;
        w = bits_for(64'(pow10(digits - 1)) * 64'd9);
        return (bin_w > w) ? bin_w : w;
    endfunction

endpackage

// File: rtl/bin2bcd_pipe_stage.sv
// -----------------------------------------------------------------------------
// bcd_digit_stage
// One pipeline stage of the converter: decides decimal digit P of the word it
// receives and passes on the remainder below 10^P.
//   clk, rst : clock, asynchronous active-high reset
//   vld_i    : upstream word valid          rdy_i : downstream stage can load
//   rem_i    : remainder entering the stage dig_i : digits decided so far
//   ovf_i    : overflow flag of the word
//   vld_o, rem_o, dig_o, ovf_o : registered stage contents
// -----------------------------------------------------------------------------
module bcd_digit_stage
    import bin2bcd_pkg::*;
#(
    parameter int P      = 1,
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld_i,
    input  logic                rdy_i,
    input  logic [BIN_W-1:0]    rem_i,
    input  logic [4*DIGITS-1:0] dig_i,
    input  logic                ovf_i,
    output logic                vld_o,
    output logic [BIN_W-1:0]    rem_o,
    output logic [4*DIGITS-1:0] dig_o,
    output logic                ovf_o
);

    localparam int            AW   = arith_width(BIN_W, DIGITS);
    localparam logic [AW-1:0] STEP = AW'(pow10(P));

    logic [AW-1:0]       rem_ext_s;
    logic [AW-1:0]       thr_s;
    logic [AW-1:0]       sub_s;
    logic [AW-1:0]       diff_s;
    logic [3:0]          digit_s;
    logic                load_s;
    logic [BIN_W-1:0]    rem_d,  rem_q;
    logic [4*DIGITS-1:0] dig_d,  dig_q;
    logic                vld_q,  ovf_q;

    // Digit select: the digit is the count of thresholds k*10^P (k=1..9)
    // that the remainder reaches; the last reached threshold is subtracted.
    always_comb begin
        rem_ext_s = AW'(rem_i);
        thr_s     = '0;
        sub_s     = '0;
        digit_s   = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            thr_s   = thr_s + STEP;
            digit_s = (rem_ext_s >= thr_s) ? (digit_s + 4'd1) : digit_s;
            sub_s   = (rem_ext_s >= thr_s) ? thr_s : sub_s;
        end
        diff_s = rem_ext_s - sub_s;
        rem_d  = BIN_W'(diff_s);
        dig_d  = dig_i;
        dig_d[4*P +: 4] = dig_i[4*P +: 4] | digit_s;
    end

    assign load_s = !vld_q || rdy_i;

    // Stage register: loads whenever it is empty or its word moves downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            rem_q <= '0;
            dig_q <= '0;
            ovf_q <= 1'b0;
        end else if (load_s) begin
            vld_q <= vld_i;
            rem_q <= rem_d;
            dig_q <= dig_d;
            ovf_q <= ovf_i;
        end
    end

    assign vld_o = vld_q;
    assign rem_o = rem_q;
    assign dig_o = dig_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bin2bcd_pipe.sv
// -----------------------------------------------------------------------------
// bin2bcd_pipe
// Fully pipelined binary-to-BCD converter, one conversion per clock,
// DIGITS-1 register stages, most significant digit first.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input word present        in_ready  : word accepted this cycle
//   bin_in     : unsigned binary value
//   out_valid  : result present            out_ready : consumer takes result
//   bcd_out    : packed BCD, units in [3:0]
//   ovf_out    : input was >= 10^DIGITS (saturated or wrapped per SATURATE)
// -----------------------------------------------------------------------------
module bin2bcd_pipe
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 10,
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf_out
);

    localparam int          NS           = DIGITS - 1;
    localparam logic [63:0] LIMIT        = 64'(pow10(DIGITS));
    localparam logic [63:0] BIN_MAX      = (64'd1 << BIN_W) - 64'd1;
    // Narrow inputs can never reach 10^DIGITS; the compare then folds away.
    localparam bit          OVF_POSSIBLE = (LIMIT <= BIN_MAX);

    logic [63:0]         bin_ext_s;
    logic                ovf_in_s;
    logic [BIN_W-1:0]    rem_in_s;
    logic                full_s;
    logic [NS-1:0]       vld_s;
    logic [NS-1:0]       dn_rdy_s;
    logic [BIN_W-1:0]    rem_s [NS];
    logic [4*DIGITS-1:0] dig_s [NS];
    logic                ovf_s [NS];
    logic [3:0]          units_s;

    // Input range check and first-stage remainder (saturate or wrap).
    always_comb begin
        bin_ext_s = 64'(bin_in);
        ovf_in_s  = OVF_POSSIBLE && (bin_ext_s >= LIMIT);
        if (!ovf_in_s) begin
            rem_in_s = bin_in;
        end else if (SATURATE) begin
            rem_in_s = BIN_W'(LIMIT - 64'd1);
        end else begin
            rem_in_s = BIN_W'(bin_ext_s % LIMIT);
        end
    end

    // Ready chain rdy[k] = !vld[k] || rdy[k+1], unrolled: a stage may advance
    // unless every stage downstream of it is full and the consumer stalls.
    always_comb begin
        dn_rdy_s = '0;
        full_s   = 1'b1;
        for (int s = NS - 1; s >= 0; s--) begin
            dn_rdy_s[s] = out_ready || !full_s;
            full_s      = full_s && vld_s[s];
        end
        in_ready = out_ready || !full_s;
    end

    for (genvar s = 0; s < NS; s++) begin : g_stage
        if (s == 0) begin : g_first
            bcd_digit_stage #(
                .P      (DIGITS - 1),
                .BIN_W  (BIN_W),
                .DIGITS (DIGITS)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .vld_i (in_valid),
                .rdy_i (dn_rdy_s[s]),
                .rem_i (rem_in_s),
                .dig_i ({(4*DIGITS){1'b0}}),
                .ovf_i (ovf_in_s),
                .vld_o (vld_s[s]),
                .rem_o (rem_s[s]),
                .dig_o (dig_s[s]),
                .ovf_o (ovf_s[s])
            );
        end else begin : g_next
            bcd_digit_stage #(
                .P      (DIGITS - 1 - s),
                .BIN_W  (BIN_W),
                .DIGITS (DIGITS)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .vld_i (vld_s[s-1]),
                .rdy_i (dn_rdy_s[s]),
                .rem_i (rem_s[s-1]),
                .dig_i (dig_s[s-1]),
                .ovf_i (ovf_s[s-1]),
                .vld_o (vld_s[s]),
                .rem_o (rem_s[s]),
                .dig_o (dig_s[s]),
                .ovf_o (ovf_s[s])
            );
        end
    end

    // The remainder leaving the last stage is below 10 and is the units digit.
    assign units_s   = 4'(rem_s[NS-1]);
    assign bcd_out   = dig_s[NS-1] | {{(4*DIGITS-4){1'b0}}, units_s};
    assign out_valid = vld_s[NS-1];
    assign ovf_out   = ovf_s[NS-1];

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_pipe
// Directed and randomized checks of bin2bcd_pipe against a decimal
// reference computed with division and modulo.
// -----------------------------------------------------------------------------
module tb_bin2bcd_pipe;

    localparam int N_RND = 10000;
    localparam int RBW [4] = '{10, 16, 20, 4};
    localparam int RDG [4] = '{4, 5, 6, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ovf, bcd} from plain decimal arithmetic.
    function automatic logic [24:0] ref_conv(input longint v, input int dg, input bit sat);
        longint      lim;
        longint      x;
        logic [23:0] b;
        logic        ovf;
        lim = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        ovf = (v >= lim);
        x   = v;
        if (ovf) x = sat ? (lim - 1) : (v % lim);
        b = '0;
        for (int i = 0; i < dg; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {ovf, b};
    endfunction

    // ---------------- directed DUT: BIN_W=10, DIGITS=4 ----------------
    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [9:0]  a_bin;
    logic [15:0] a_bcd;

    bin2bcd_pipe #(.BIN_W(10), .DIGITS(4), .SATURATE(1'b1)) u_dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .bin_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_out(a_bcd), .ovf_out(a_ovf));

    // ---------------- overflow DUTs: BIN_W=10, DIGITS=3 ----------------
    logic        x_rst, x_in_valid, x_out_ready;
    logic [9:0]  x_bin;
    logic        s_in_ready, s_out_valid, s_ovf, w_in_ready, w_out_valid, w_ovf;
    logic [11:0] s_bcd, w_bcd;

    bin2bcd_pipe #(.BIN_W(10), .DIGITS(3), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_ready(s_in_ready),
        .bin_in(x_bin), .out_valid(s_out_valid), .out_ready(x_out_ready),
        .bcd_out(s_bcd), .ovf_out(s_ovf));

    bin2bcd_pipe #(.BIN_W(10), .DIGITS(3), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_ready(w_in_ready),
        .bin_in(x_bin), .out_valid(w_out_valid), .out_ready(x_out_ready),
        .bcd_out(w_bcd), .ovf_out(w_ovf));

    // ---------------- randomized DUTs ----------------
    logic r_rst;

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int BW = RBW[g];
        localparam int DG = RDG[g];
        logic          in_valid, in_ready, out_valid, out_ready, ovf;
        logic [BW-1:0] bin;
        logic [4*DG-1:0] bcd;
        bit            done = 1'b0;
        logic [24:0]   exp_q [$];

        bin2bcd_pipe #(.BIN_W(BW), .DIGITS(DG), .SATURATE(1'b1)) u_dut (
            .clk(clk), .rst(r_rst), .in_valid(in_valid), .in_ready(in_ready),
            .bin_in(bin), .out_valid(out_valid), .out_ready(out_ready),
            .bcd_out(bcd), .ovf_out(ovf));

        initial begin
            int            sent;
            int            cyc;
            logic          stall;
            logic [4*DG-1:0] held;
            logic [24:0]   e;
            sent = 0; cyc = 0; stall = 1'b0; held = '0;
            in_valid = 1'b0; out_ready = 1'b0; bin = '0;
            @(negedge clk);
            while (r_rst) @(negedge clk);
            while ((sent < N_RND || exp_q.size() > 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                in_valid  = (sent < N_RND) && ($urandom_range(3) != 0);
                bin       = BW'($urandom);
                out_ready = ($urandom_range(2) != 0);
                #1;
                if (stall) begin
                    check_eq("rnd_hold_valid", 64'(out_valid), 64'd1);
                    check_eq("rnd_hold_bcd", 64'(bcd), 64'(held));
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_conv(longint'(bin), DG, 1'b1));
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rnd_spurious", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rnd_bcd", 64'(bcd), 64'(e[23:0]));
                        check_eq("rnd_ovf", 64'(ovf), 64'(e[24]));
                    end
                end
                stall = out_valid && !out_ready;
                held  = bcd;
            end
            check_eq("rnd_sent", 64'(sent), 64'(N_RND));
            check_eq("rnd_drained", 64'(exp_q.size()), 64'd0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            done = 1'b1;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic a_single(input logic [9:0] v, input logic [15:0] exp_bcd);
        @(negedge clk);
        a_in_valid = 1'b1; a_bin = v; a_out_ready = 1'b1;
        #1 check_eq("single_in_ready", 64'(a_in_ready), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1 check_eq("single_latency", 64'(a_out_valid), 64'(c == 3));
        end
        check_eq("single_bcd", 64'(a_bcd), 64'(exp_bcd));
        check_eq("single_ovf", 64'(a_ovf), 64'd0);
        @(negedge clk);
        #1 check_eq("single_drained", 64'(a_out_valid), 64'd0);
    endtask

    task automatic x_single(input logic [9:0] v, input logic [11:0] sb, input logic so,
                            input logic [11:0] wb, input logic wo);
        @(negedge clk);
        x_in_valid = 1'b1; x_bin = v; x_out_ready = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            x_in_valid = 1'b0;
            #1;
            check_eq("ovf_sat_latency", 64'(s_out_valid), 64'(c == 2));
            check_eq("ovf_wrap_latency", 64'(w_out_valid), 64'(c == 2));
        end
        check_eq("ovf_sat_bcd", 64'(s_bcd), 64'(sb));
        check_eq("ovf_sat_flag", 64'(s_ovf), 64'(so));
        check_eq("ovf_wrap_bcd", 64'(w_bcd), 64'(wb));
        check_eq("ovf_wrap_flag", 64'(w_ovf), 64'(wo));
    endtask

    logic [9:0]  t1_in  [5] = '{10'd0, 10'd9, 10'd10, 10'd999, 10'd1023};
    logic [15:0] t1_exp [5] = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h1023};
    logic [9:0]  bp_in  [3] = '{10'd123, 10'd456, 10'd789};
    logic [15:0] bp_exp [3] = '{16'h0123, 16'h0456, 16'h0789};
    logic [9:0]  ov_in  [4] = '{10'd1000, 10'd1023, 10'd999, 10'd5};
    logic [11:0] ov_sb  [4] = '{12'h999, 12'h999, 12'h999, 12'h005};
    logic        ov_so  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] ov_wb  [4] = '{12'h000, 12'h023, 12'h999, 12'h005};
    logic        ov_wo  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [24:0] e;
        int          guard;
        logic        all_done;

        // Reset with input valid asserted: nothing may be captured.
        a_rst = 1'b1; x_rst = 1'b1; r_rst = 1'b1;
        a_in_valid = 1'b1; a_bin = 10'd300; a_out_ready = 1'b1;
        x_in_valid = 1'b1; x_bin = 10'd300; x_out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst_bcd", 64'(a_bcd), 64'd0);
        check_eq("rst_ovf", 64'(a_ovf), 64'd0);
        repeat (3) @(negedge clk);
        #1 check_eq("rst_no_capture", 64'(a_out_valid), 64'd0);
        a_in_valid = 1'b0; x_in_valid = 1'b0;
        #1 a_rst = 1'b0; x_rst = 1'b0; r_rst = 1'b0;
        #1 check_eq("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Single conversions.
        for (int i = 0; i < 5; i++) a_single(t1_in[i], t1_exp[i]);

        // Back-to-back stream 0..999.
        for (int i = 0; i < 1003; i++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            a_in_valid  = (i < 1000);
            a_bin       = 10'(i);
            #1;
            if (i < 1000) check_eq("stream_in_ready", 64'(a_in_ready), 64'd1);
            if (i >= 3) begin
                e = ref_conv(longint'(i - 3), 4, 1'b1);
                check_eq("stream_valid", 64'(a_out_valid), 64'd1);
                check_eq("stream_bcd", 64'(a_bcd), 64'(e[15:0]));
            end else begin
                check_eq("stream_empty", 64'(a_out_valid), 64'd0);
            end
        end

        // Backpressure.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_out_ready = 1'b0; a_in_valid = 1'b1; a_bin = bp_in[k];
            #1 check_eq("bp_in_ready_open", 64'(a_in_ready), 64'd1);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            check_eq("bp_in_ready_full", 64'(a_in_ready), 64'd0);
            check_eq("bp_hold_valid", 64'(a_out_valid), 64'd1);
            check_eq("bp_hold_bcd", 64'(a_bcd), 64'h0123);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            #1;
            check_eq("bp_drain_valid", 64'(a_out_valid), 64'd1);
            check_eq("bp_drain_bcd", 64'(a_bcd), 64'(bp_exp[k]));
        end
        @(negedge clk);
        #1 check_eq("bp_drain_empty", 64'(a_out_valid), 64'd0);

        // Overflow handling, saturate and wrap.
        for (int i = 0; i < 4; i++) x_single(ov_in[i], ov_sb[i], ov_so[i], ov_wb[i], ov_wo[i]);

        // Reset mid-flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_out_ready = 1'b1; a_in_valid = 1'b1; a_bin = 10'(7 + k);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        check_eq("midrst_pre_valid", 64'(a_out_valid), 64'd1);
        check_eq("midrst_pre_bcd", 64'(a_bcd), 64'h0007);
        #1 a_rst = 1'b1; a_in_valid = 1'b1; a_bin = 10'd77;
        #1;
        check_eq("midrst_async_valid", 64'(a_out_valid), 64'd0);
        check_eq("midrst_async_bcd", 64'(a_bcd), 64'd0);
        @(negedge clk);
        #2 a_rst = 1'b0; a_in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1 check_eq("midrst_no_stale", 64'(a_out_valid), 64'd0);
        end
        a_single(10'd42, 16'h0042);

        // Wait for the randomized runs.
        guard = 0;
        all_done = 1'b0;
        while (!all_done && guard < 80000) begin
            @(negedge clk);
            guard++;
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done;
        end
        check_eq("rnd_complete", 64'(all_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
